// File: rtl/scu_dispatch.sv
// Binds streamed (act, weight) jobs to free SCU lanes, issues their MACs and returns captured psums round-robin.
// Lane issue is one cycle after accept; in_ready drops only for a new job with no FREE lane; out_* held until out_ready.
module scu_dispatch #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int TAG_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_act,
    input  logic [DATA_W-1:0]             in_weight,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic [TAG_W-1:0]              in_tag,
    output logic [NUM_LANES-1:0]          lane_valid,
    output logic [NUM_LANES-1:0]          lane_clr,
    output logic [NUM_LANES*DATA_W-1:0]   lane_act,
    output logic [NUM_LANES*DATA_W-1:0]   lane_weight,
    input  logic [NUM_LANES*ACC_W-1:0]    lane_psum,
    input  logic [NUM_LANES-1:0]          lane_vout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_psum,
    output logic [TAG_W-1:0]              out_tag,
    output logic [$clog2(NUM_LANES)-1:0]  out_lane,
    output logic                          proto_err
);
    localparam int LW = $clog2(NUM_LANES);

    typedef enum logic [1:0] {S_FREE, S_ACCUM, S_WAIT, S_DONE} lane_st_t;

    lane_st_t                    r_state     [NUM_LANES];
    lane_st_t                    w_state_nxt [NUM_LANES];
    logic [TAG_W-1:0]            r_tag       [NUM_LANES];
    logic [ACC_W-1:0]            r_psum      [NUM_LANES];
    logic                        r_bound;
    logic                        r_run;
    logic                        r_err;
    logic [LW-1:0]               r_cur;
    logic [LW-1:0]               r_alloc_ptr;
    logic [LW-1:0]               r_out_ptr;
    logic [NUM_LANES-1:0]        r_lane_valid;
    logic [NUM_LANES-1:0]        r_lane_clr;
    logic [NUM_LANES*DATA_W-1:0] r_lane_act;
    logic [NUM_LANES*DATA_W-1:0] r_lane_weight;

    logic          w_any_free, w_any_done;
    logic          w_in_rdy, w_acc, w_start, w_cont, w_issue, w_perr, w_hs;
    logic [LW-1:0] w_alloc, w_sel, w_lane, w_aidx, w_oidx;

    // Descending scan so the lowest offset from each pointer wins.
    always_comb begin
        w_any_free = 1'b0;
        w_alloc    = r_alloc_ptr;
        w_any_done = 1'b0;
        w_sel      = r_out_ptr;
        w_aidx     = r_alloc_ptr;
        w_oidx     = r_out_ptr;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            w_aidx = r_alloc_ptr + LW'(k);
            if (r_state[w_aidx] == S_FREE) begin
                w_any_free = 1'b1;
                w_alloc    = w_aidx;
            end
            w_oidx = r_out_ptr + LW'(k);
            if (r_state[w_oidx] == S_DONE) begin
                w_any_done = 1'b1;
                w_sel      = w_oidx;
            end
        end
    end

    assign w_in_rdy = r_run & (r_bound | ~in_first | w_any_free);
    assign w_acc    = in_valid & w_in_rdy;
    assign w_start  = w_acc & ~r_bound & in_first;
    assign w_cont   = w_acc & r_bound;
    assign w_issue  = w_start | w_cont;
    assign w_perr   = w_acc & (r_bound ? in_first : ~in_first);
    assign w_lane   = r_bound ? r_cur : w_alloc;
    assign w_hs     = w_any_done & out_ready;

    // Transitions are disjoint per lane: alloc only hits FREE, vout only WAIT, handshake only DONE.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_state_nxt[i] = r_state[i];
            unique case (r_state[i])
                S_FREE:  if (w_start && w_alloc == LW'(i))
                             w_state_nxt[i] = in_last ? S_WAIT : S_ACCUM;
                S_ACCUM: if (w_cont && in_last && r_cur == LW'(i))
                             w_state_nxt[i] = S_WAIT;
                S_WAIT:  if (lane_vout[i])
                             w_state_nxt[i] = S_DONE;
                S_DONE:  if (w_hs && w_sel == LW'(i))
                             w_state_nxt[i] = S_FREE;
                default: w_state_nxt[i] = S_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) r_state[i] <= S_FREE;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_tag[i]  <= '0;
                r_psum[i] <= '0;
            end
            r_bound       <= 1'b0;
            r_run         <= 1'b0;
            r_err         <= 1'b0;
            r_cur         <= '0;
            r_alloc_ptr   <= '0;
            r_out_ptr     <= '0;
            r_lane_valid  <= '0;
            r_lane_clr    <= '0;
            r_lane_act    <= '0;
            r_lane_weight <= '0;
        end else begin
            r_run        <= 1'b1;
            r_lane_valid <= '0;
            r_lane_clr   <= '0;
            if (w_perr) r_err <= 1'b1;
            if (w_start) begin
                r_bound       <= ~in_last;
                r_cur         <= w_alloc;
                r_alloc_ptr   <= w_alloc + 1'b1;
                r_tag[w_alloc] <= in_tag;
            end else if (w_cont && in_last) begin
                r_bound <= 1'b0;
            end
            if (w_issue) begin
                r_lane_valid[w_lane]                  <= 1'b1;
                r_lane_clr[w_lane]                    <= w_start;
                r_lane_act[w_lane*DATA_W +: DATA_W]    <= in_act;
                r_lane_weight[w_lane*DATA_W +: DATA_W] <= in_weight;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (r_state[i] == S_WAIT && lane_vout[i])
                    r_psum[i] <= lane_psum[i*ACC_W +: ACC_W];
            end
            if (w_hs) r_out_ptr <= w_sel + 1'b1;
        end
    end

    always_comb begin
        in_ready    = w_in_rdy;
        lane_valid  = r_lane_valid;
        lane_clr    = r_lane_clr;
        lane_act    = r_lane_act;
        lane_weight = r_lane_weight;
        out_valid   = w_any_done;
        out_psum    = w_any_done ? r_psum[w_sel] : '0;
        out_tag     = w_any_done ? r_tag[w_sel] : '0;
        out_lane    = w_any_done ? w_sel : '0;
        proto_err   = r_err;
    end

endmodule

// File: tb/tb_scu_dispatch.sv
// Bench for scu_dispatch: pipelined SCU model per lane, expected results queued at issue and checked by an output monitor.
module tb_scu_dispatch;
    localparam int NL = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int TW = 8;
    localparam int LW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_act = '0;
    logic [DW-1:0]     in_weight = '0;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic [TW-1:0]     in_tag = '0;
    logic [NL-1:0]     lane_valid, lane_clr;
    logic [NL*DW-1:0]  lane_act, lane_weight;
    logic [NL*AW-1:0]  lane_psum;
    logic [NL-1:0]     lane_vout;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [AW-1:0]     out_psum;
    logic [TW-1:0]     out_tag;
    logic [LW-1:0]     out_lane;
    logic              proto_err;

    always #5 clk = ~clk;

    scu_dispatch #(.NUM_LANES(NL), .DATA_W(DW), .ACC_W(AW), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_weight(in_weight),
        .in_first(in_first), .in_last(in_last), .in_tag(in_tag),
        .lane_valid(lane_valid), .lane_clr(lane_clr), .lane_act(lane_act), .lane_weight(lane_weight),
        .lane_psum(lane_psum), .lane_vout(lane_vout),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .out_tag(out_tag),
        .out_lane(out_lane), .proto_err(proto_err)
    );

    // SCU model: product stage then accumulate stage; vout marks the end of a MAC run.
    logic [NL-1:0]        m_pv, m_av, m_pclr;
    logic signed [AW-1:0] m_prod [NL];
    logic signed [AW-1:0] m_acc  [NL];

    function automatic logic signed [AW-1:0] mul(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        logic signed [AW-1:0] ea, eb;
        ea = a;
        eb = b;
        return ea * eb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pv   <= '0;
            m_av   <= '0;
            m_pclr <= '0;
            for (int i = 0; i < NL; i++) begin
                m_prod[i] <= '0;
                m_acc[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NL; i++) begin
                m_pv[i]   <= lane_valid[i];
                m_pclr[i] <= lane_clr[i];
                m_av[i]   <= m_pv[i];
                if (lane_valid[i]) m_prod[i] <= mul(lane_act[i*DW +: DW], lane_weight[i*DW +: DW]);
                if (m_pv[i]) m_acc[i] <= m_pclr[i] ? m_prod[i] : m_acc[i] + m_prod[i];
            end
        end
    end

    assign lane_vout = m_av & ~m_pv;
    always_comb begin
        lane_psum = '0;
        for (int i = 0; i < NL; i++) lane_psum[i*AW +: AW] = m_acc[i];
    end

    typedef struct packed {
        logic [AW-1:0] psum;
        logic [TW-1:0] tag;
        logic [LW-1:0] lane;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   total = 0;
    int   bad = 0;
    int   n_valid = 0;
    int   n_clr = 0;
    int   g_stalls = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (lane_valid[i]) n_valid++;
                if (lane_clr[i]) n_clr++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result psum=%0d tag=%0d lane=%0d, none expected",
                             $signed(out_psum), out_tag, out_lane);
                end else begin
                    m_e = sb.pop_front();
                    if (out_psum !== m_e.psum || out_tag !== m_e.tag || out_lane !== m_e.lane) begin
                        bad++;
                        $display("FAIL result got psum=%0d tag=%0d lane=%0d want psum=%0d tag=%0d lane=%0d",
                                 $signed(out_psum), out_tag, out_lane, $signed(m_e.psum), m_e.tag, m_e.lane);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic drive(input logic signed [DW-1:0] a, input logic signed [DW-1:0] w,
                         input logic f, input logic l, input logic [TW-1:0] t);
        in_valid  = 1'b1;
        in_act    = a;
        in_weight = w;
        in_first  = f;
        in_last   = l;
        in_tag    = t;
    endtask

    // Returns #1 after the accepting edge.
    task automatic wait_acc();
        logic r;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) return;
            g_stalls++;
        end
        total++;
        bad++;
        $display("FAIL accept_timeout got=no_accept want=accept");
    endtask

    task automatic send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] w,
                        input logic f, input logic l, input logic [TW-1:0] t);
        drive(a, w, f, l, t);
        wait_acc();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 80; c++) begin
            if (sb.size() == 0) return;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout_pending", sb.size(), 0);
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int v0, c0, s0;

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_lane_valid", lane_valid, 0);
        chk("rst_proto_err", proto_err, 0);
        do_reset();

        // Single three-element job, lane 0, latency check
        out_ready = 1'b1;
        v0 = n_valid; c0 = n_clr;
        sb.push_back('{psum: 12, tag: 5, lane: 0});
        send(2, 3, 1, 0, 5);
        send(4, -1, 0, 0, 0);
        send(1, 10, 0, 1, 0);
        idle();
        chk("t1_last_issue_valid", lane_valid, 4'b0001);
        chk("t1_last_issue_clr", lane_clr, 4'b0000);
        chk("t1_outv_e0", out_valid, 0);
        @(posedge clk); #1;
        chk("t1_outv_e1", out_valid, 0);
        @(posedge clk); #1;
        chk("t1_outv_e2", out_valid, 0);
        @(posedge clk); #1;
        chk("t1_outv_e3", out_valid, 1);
        drain();
        chk("t1_valid_pulses", n_valid - v0, 3);
        chk("t1_clr_pulses", n_clr - c0, 1);

        // One-element job lands on lane 1 (alloc pointer advanced)
        sb.push_back('{psum: -21, tag: 9, lane: 1});
        send(-3, 7, 1, 1, 9);
        idle();
        chk("t2_valid", lane_valid, 4'b0010);
        chk("t2_clr", lane_clr, 4'b0010);
        @(posedge clk); #1;
        chk("t2_valid_one_cycle", lane_valid, 4'b0000);
        drain();

        // All lanes held DONE; fifth job waits for a free lane
        do_reset();
        sb.push_back('{psum: 1, tag: 1, lane: 0});
        sb.push_back('{psum: 6, tag: 2, lane: 1});
        sb.push_back('{psum: -20, tag: 3, lane: 2});
        sb.push_back('{psum: -49, tag: 4, lane: 3});
        sb.push_back('{psum: -200, tag: 5, lane: 0});
        send(1, 1, 1, 1, 1);
        send(2, 3, 1, 1, 2);
        send(-4, 5, 1, 1, 3);
        send(7, -7, 1, 1, 4);
        idle();
        repeat (5) begin @(posedge clk); #1; end
        chk("t3_out_valid_held", out_valid, 1);
        chk("t3_out_tag_held", out_tag, 1);
        chk("t3_out_lane_held", out_lane, 0);
        drive(100, -2, 1, 1, 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_in_ready_full", in_ready, 0);
        end
        @(posedge clk); #1;
        chk("t3_out_tag_stable", out_tag, 1);
        out_ready = 1'b1;
        wait_acc();
        idle();
        drain();

        // Back-to-back jobs with no bubbles
        do_reset();
        out_ready = 1'b1;
        s0 = g_stalls;
        sb.push_back('{psum: 44, tag: 8'hA, lane: 0});
        sb.push_back('{psum: -15, tag: 8'hB, lane: 1});
        send(1, 2, 1, 0, 8'hA);
        send(3, 4, 0, 0, 0);
        send(5, 6, 0, 1, 0);
        send(-1, -1, 1, 0, 8'hB);
        send(-2, 8, 0, 1, 0);
        idle();
        chk("t4_stalls", g_stalls - s0, 0);
        drain();

        // Protocol errors
        chk("t5_proto_clear", proto_err, 0);
        v0 = n_valid;
        send(5, 5, 0, 0, 0);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_proto_set", proto_err, 1);
        chk("t5_dropped_no_issue", n_valid - v0, 0);
        v0 = n_valid; c0 = n_clr;
        sb.push_back('{psum: 8, tag: 8'h22, lane: 2});
        send(2, 2, 1, 0, 8'h22);
        send(3, 3, 1, 0, 8'h77);
        send(1, -5, 0, 1, 0);
        idle();
        drain();
        chk("t5_proto_sticky", proto_err, 1);
        chk("t5_fold_clr", n_clr - c0, 1);
        chk("t5_fold_valid", n_valid - v0, 3);

        // Reset with one lane DONE and another in WAIT
        out_ready = 1'b0;
        sb.push_back('{psum: 1, tag: 8'h61, lane: 3});
        send(1, 1, 1, 1, 8'h61);
        idle();
        repeat (5) begin @(posedge clk); #1; end
        chk("t6_done_before_rst", out_valid, 1);
        sb.push_back('{psum: 4, tag: 8'h62, lane: 0});
        send(2, 2, 1, 1, 8'h62);
        idle();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_lane_valid", lane_valid, 0);
        chk("t6_rst_lane_clr", lane_clr, 0);
        chk("t6_rst_lane_act", lane_act, 0);
        chk("t6_rst_lane_weight", lane_weight, 0);
        chk("t6_rst_out_psum", out_psum, 0);
        chk("t6_rst_out_tag", out_tag, 0);
        chk("t6_rst_out_lane", out_lane, 0);
        chk("t6_rst_proto_err", proto_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        sb.push_back('{psum: -9, tag: 8'h63, lane: 0});
        send(3, -3, 1, 1, 8'h63);
        idle();
        drain();

        repeat (4) @(posedge clk);
        chk("end_queue_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
